// File: rtl/tlc5940_frame_buffer.sv
// Double-buffered grayscale store for four TLC5940 chains of 16 channels.
// Writes land in a shadow bank; a commit copies the shadow bank into the
// active bank, which drives data_register0..3. The copy is aligned to the
// driver's XLAT rise, or forced after COMMIT_TIMEOUT cycles without one.
module tlc5940_frame_buffer #(
    parameter logic [31:0] COMMIT_TIMEOUT = 32'd1000000,
    parameter logic [11:0] CLEAR_VALUE    = 12'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [1:0]     wr_chain,
    input  logic [3:0]     wr_chan,
    input  logic [11:0]    wr_value,
    input  logic           clear_req,
    input  logic           commit_req,
    input  logic           xlat_in,
    output logic           busy,
    output logic           commit_done,
    output logic [193:2]   data_register0,
    output logic [193:2]   data_register1,
    output logic [193:2]   data_register2,
    output logic [193:2]   data_register3
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        WAIT_SYNC = 2'd2,
        COPY      = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = COMMIT_TIMEOUT - 32'd1;

    state_t        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          xlat_q;
    logic          commit_done_q;
    logic          xlat_rise;
    logic          wr_fire;
    logic [3:0][191:0] active_bus;

    assign xlat_rise   = xlat_in & ~xlat_q;
    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign wr_fire     = wr_valid & wr_ready;
    assign commit_done = commit_done_q;

    assign data_register0 = active_bus[0];
    assign data_register1 = active_bus[1];
    assign data_register2 = active_bus[2];
    assign data_register3 = active_bus[3];

    // State, clear index, timeout counter, xlat edge register and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 6'd0;
            cnt_q         <= 32'd0;
            xlat_q        <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            xlat_q        <= xlat_in;
            commit_done_q <= (state_q == COPY);
        end
    end

    // Next-state logic; requests outside IDLE are ignored by construction
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = 6'd0;
                end else if (commit_req) begin
                    state_d = WAIT_SYNC;
                    cnt_d   = 32'd0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = IDLE;
                end
            end
            WAIT_SYNC: begin
                // Forced copy keeps a driver held in reset from stalling commits
                if (xlat_rise || (cnt_q == TIMEOUT_LAST)) begin
                    state_d = COPY;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            COPY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One shadow/active pair per chain; index {chain, chan} selects the field
    for (genvar gi = 0; gi < 4; gi++) begin : gen_chain
        logic [193:2] shadow_q;
        logic [193:2] active_q;

        // Shadow takes writes in IDLE and clear fills in CLEAR; active follows on COPY
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (wr_fire && (wr_chain == 2'(gi))) begin
                    shadow_q[12*wr_chan + 2 +: 12] <= wr_value;
                end
                if ((state_q == CLEAR) && (idx_q[5:4] == 2'(gi))) begin
                    shadow_q[12*idx_q[3:0] + 2 +: 12] <= CLEAR_VALUE;
                end
                if (state_q == COPY) begin
                    active_q <= shadow_q;
                end
            end
        end

        assign active_bus[gi] = active_q;
    end

endmodule

// File: tb/tb_tlc5940_frame_buffer.sv
// Self-checking bench for tlc5940_frame_buffer: directed scenarios plus a
// randomized write/commit/clear phase, all against an array-based model of
// the shadow and active banks.
module tb_tlc5940_frame_buffer;

    localparam int T = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [1:0]   wr_chain = '0;
    logic [3:0]   wr_chan = '0;
    logic [11:0]  wr_value = '0;
    logic         clear_req = 1'b0;
    logic         commit_req = 1'b0;
    logic         xlat_in = 1'b0;
    logic         busy;
    logic         commit_done;
    logic [193:2] data_register0, data_register1, data_register2, data_register3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: channel values indexed by chain*16 + chan
    logic [11:0] m_shadow [64];
    logic [11:0] m_active [64];

    tlc5940_frame_buffer #(
        .COMMIT_TIMEOUT(32'(T)),
        .CLEAR_VALUE   (12'd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_chain      (wr_chain),
        .wr_chan       (wr_chan),
        .wr_value      (wr_value),
        .clear_req     (clear_req),
        .commit_req    (commit_req),
        .xlat_in       (xlat_in),
        .busy          (busy),
        .commit_done   (commit_done),
        .data_register0(data_register0),
        .data_register1(data_register1),
        .data_register2(data_register2),
        .data_register3(data_register3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(string tag, logic [191:0] obs, logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel n of a chain sits at bit offset 12*n above bit 2
    function automatic logic [191:0] exp_vec(int chain);
        logic [191:0] v;
        v = '0;
        for (int n = 0; n < 16; n++) v[12*n +: 12] = m_active[chain*16 + n];
        return v;
    endfunction

    function automatic logic [191:0] dut_vec(int chain);
        case (chain)
            0: return data_register0;
            1: return data_register1;
            2: return data_register2;
            default: return data_register3;
        endcase
    endfunction

    task automatic check_outputs(string tag);
        for (int c = 0; c < 4; c++)
            check_eq($sformatf("%s_data%0d", tag, c), dut_vec(c), exp_vec(c));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    task automatic do_write(int ch, int cn, logic [11:0] v);
        check_eq("wr_ready_before_write", 192'(wr_ready), 192'(1));
        wr_valid = 1'b1; wr_chain = 2'(ch); wr_chan = 4'(cn); wr_value = v;
        tick();
        wr_valid = 1'b0;
        m_shadow[ch*16 + cn] = v;
        $display("write chain%0d ch%0d = %h", ch, cn, v);
    endtask

    task automatic issue_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check_eq("busy_after_commit", 192'(busy), 192'(1));
    endtask

    // Waiting starts right after the commit edge; WAIT_SYNC counts 0..T-1.
    task automatic finish_commit(int dly, bit use_timeout, bit settle);
        int waits;
        waits = use_timeout ? T : dly;
        for (int k = 1; k <= waits; k++) begin
            check_eq("no_early_done", 192'(commit_done), 192'(0));
            check_eq("wr_ready_low_waiting", 192'(wr_ready), 192'(0));
            tick();
        end
        if (!use_timeout) begin
            xlat_in = 1'b1;
            tick();
            xlat_in = 1'b0;
            check_eq("done_low_at_rise", 192'(commit_done), 192'(0));
            check_eq("busy_in_copy", 192'(busy), 192'(1));
        end
        check_outputs("old_before_copy");
        tick();
        for (int i = 0; i < 64; i++) m_active[i] = m_shadow[i];
        check_eq("commit_done_pulse", 192'(commit_done), 192'(1));
        check_outputs("after_copy");
        $display("commit %s dly=%0d published", use_timeout ? "timeout" : "xlat", waits);
        if (settle) begin
            tick();
            check_eq("commit_done_single", 192'(commit_done), 192'(0));
            check_eq("ready_after_commit", 192'(wr_ready), 192'(1));
        end
    endtask

    task automatic do_clear(bit with_commit);
        clear_req = 1'b1; commit_req = with_commit;
        tick();
        clear_req = 1'b0; commit_req = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check_eq("busy_in_clear", 192'(busy), 192'(1));
            check_eq("no_done_in_clear", 192'(commit_done), 192'(0));
            commit_req = (k == 10);
            clear_req  = (k == 30);
            xlat_in    = (k == 20);
            tick();
        end
        commit_req = 1'b0; clear_req = 1'b0; xlat_in = 1'b0;
        for (int i = 0; i < 64; i++) m_shadow[i] = 12'd0;
        check_eq("idle_after_clear", 192'(busy), 192'(0));
        check_eq("no_done_after_clear", 192'(commit_done), 192'(0));
        check_outputs("active_kept_by_clear");
        $display("clear done (with_commit=%0d)", with_commit);
    endtask

    initial begin
        int ch, cn, r;
        model_reset();
        tick();
        tick();
        check_eq("reset_wr_ready", 192'(wr_ready), 192'(1));
        check_eq("reset_busy", 192'(busy), 192'(0));
        check_eq("reset_done", 192'(commit_done), 192'(0));
        check_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Chain0 ch15 via xlat-aligned commit
        do_write(0, 15, 12'hABC);
        issue_commit();
        finish_commit(3, 1'b0, 1'b1);

        // Chain2 ch0 via forced timeout
        do_write(2, 0, 12'h123);
        issue_commit();
        finish_commit(0, 1'b1, 1'b1);

        // Write held pending across a commit
        issue_commit();
        wr_valid = 1'b1; wr_chain = 2'd1; wr_chan = 4'd5; wr_value = 12'h0FF;
        finish_commit(4, 1'b0, 1'b0);
        check_eq("ready_back_after_copy", 192'(wr_ready), 192'(1));
        tick();
        wr_valid = 1'b0;
        m_shadow[1*16 + 5] = 12'h0FF;
        check_eq("single_done_pending", 192'(commit_done), 192'(0));
        check_outputs("pending_not_published");
        issue_commit();
        finish_commit(2, 1'b0, 1'b1);

        // Clear and commit together over an all-FFF shadow
        for (int i = 0; i < 64; i++) do_write(i / 16, i % 16, 12'hFFF);
        do_clear(1'b1);
        issue_commit();
        finish_commit(1, 1'b0, 1'b1);

        // Write and commit in the same IDLE cycle
        wr_valid = 1'b1; wr_chain = 2'd3; wr_chan = 4'd7; wr_value = 12'h800;
        commit_req = 1'b1;
        tick();
        wr_valid = 1'b0; commit_req = 1'b0;
        m_shadow[3*16 + 7] = 12'h800;
        finish_commit(0, 1'b0, 1'b1);

        // Reset while waiting for sync
        do_write(1, 9, 12'h5A5);
        issue_commit();
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_wr_ready", 192'(wr_ready), 192'(1));
        check_eq("rst_busy", 192'(busy), 192'(0));
        check_eq("rst_done", 192'(commit_done), 192'(0));
        check_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        xlat_in = 1'b1;
        tick();
        xlat_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("no_done_after_reset", 192'(commit_done), 192'(0));
            tick();
        end
        check_outputs("after_reset_xlat");
        issue_commit();
        finish_commit(2, 1'b0, 1'b1);

        // Randomized writes, commits and clears
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(1, 6);
            for (int w = 0; w < r; w++) begin
                ch = $urandom_range(0, 3);
                cn = $urandom_range(0, 15);
                do_write(ch, cn, 12'($urandom));
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_clear(1'($urandom));
            end else if (r == 1) begin
                issue_commit();
                finish_commit(0, 1'b1, 1'b1);
            end else if (r == 2) begin
                ch = $urandom_range(0, 3);
                cn = $urandom_range(0, 15);
                wr_valid = 1'b1; wr_chain = 2'(ch); wr_chan = 4'(cn);
                wr_value = 12'($urandom);
                commit_req = 1'b1;
                m_shadow[ch*16 + cn] = wr_value;
                tick();
                wr_valid = 1'b0; commit_req = 1'b0;
                finish_commit($urandom_range(0, 8), 1'b0, 1'b1);
            end else begin
                issue_commit();
                finish_commit($urandom_range(0, 8), 1'b0, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
